// File: rtl/rgb_lcd_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rgb_lcd_timing_gen: panel-ID selected RGB LCD timing, sync/DE, power-up  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module rgb_lcd_timing_gen #(
  parameter int   CW         = 11,
  parameter int   DW         = 16,
  parameter int   REQ_LEAD   = 1,
  parameter int   RST_CYCLES = 1000,
  parameter logic HS_ACT     = 1'b0,
  parameter logic VS_ACT     = 1'b0
) (
  input  logic          lcd_clk,
  input  logic          sys_rst_n,
  input  logic [15:0]   lcd_id,
  input  logic          mode_hv,
  input  logic [DW-1:0] pixel_data,
  output logic          data_req,
  output logic [CW-1:0] pixel_xpos,
  output logic [CW-1:0] pixel_ypos,
  output logic          lcd_hs,
  output logic          lcd_vs,
  output logic          lcd_de,
  output logic [DW-1:0] lcd_data,
  output logic          lcd_pclk,
  output logic          lcd_rst,
  output logic          lcd_bl,
  output logic          frame_start,
  output logic          timing_chg,
  output logic [CW-1:0] active_w,
  output logic [CW-1:0] active_h
);

  typedef struct packed {
    logic [CW-1:0] hs, hb, hd, ht, vs, vb, vd, vt;
  } timing_t;

  function automatic timing_t mk(input int hs, input int hb, input int hd, input int ht,
                                 input int vs, input int vb, input int vd, input int vt);
    timing_t t;
    t.hs = CW'(hs); t.hb = CW'(hb); t.hd = CW'(hd); t.ht = CW'(ht);
    t.vs = CW'(vs); t.vb = CW'(vb); t.vd = CW'(vd); t.vt = CW'(vt);
    return t;
  endfunction

  localparam timing_t T_4342 = mk(41, 2, 480, 525, 10, 2, 272, 286);
  localparam timing_t T_X84  = mk(128, 88, 800, 1056, 2, 33, 480, 525);
  localparam timing_t T_7016 = mk(20, 140, 1024, 1344, 3, 20, 600, 635);
  localparam timing_t T_1018 = mk(10, 80, 1280, 1440, 3, 10, 800, 823);

  localparam int            RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
  localparam logic [CW-1:0]  LEAD     = CW'(REQ_LEAD);

  typedef enum logic [1:0] {
    RST_HOLD   = 2'd0,
    WAIT_FRAME = 2'd1,
    RUN        = 2'd2
  } state_t;

  state_t         state, state_next;
  timing_t        cur, tbl;
  logic [CW-1:0]  cnt_h, cnt_v, cnt_h_next, cnt_v_next;
  logic [RCW-1:0] rst_cnt;
  logic           h_end, frame_end;
  logic           hs_on, vs_on, chg_q, rst_q, bl_q;

  // Unknown IDs resolve to the timing already in force, so they never cause a change.
  always_comb begin
    tbl = cur;
    case (lcd_id)
      16'h4342:           tbl = T_4342;
      16'h4384, 16'h7084: tbl = T_X84;
      16'h7016:           tbl = T_7016;
      16'h1018:           tbl = T_1018;
      default:            tbl = cur;
    endcase
  end

  assign h_end      = (cnt_h == cur.ht - CW'(1));
  assign frame_end  = h_end && (cnt_v == cur.vt - CW'(1));
  assign cnt_h_next = h_end ? '0 : cnt_h + CW'(1);
  assign cnt_v_next = frame_end ? '0 : (h_end ? cnt_v + CW'(1) : cnt_v);

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h <= '0;
      cnt_v <= '0;
      cur   <= T_4342;
      chg_q <= 1'b0;
      hs_on <= 1'b0;
      vs_on <= 1'b0;
    end else begin
      cnt_h <= cnt_h_next;
      cnt_v <= cnt_v_next;
      chg_q <= frame_end && (tbl != cur);
      if (frame_end) cur <= tbl;
      // Sync phases are computed for the upcoming counter position and timing.
      hs_on <= (cnt_h_next < (frame_end ? tbl.hs : cur.hs));
      vs_on <= (cnt_v_next < (frame_end ? tbl.vs : cur.vs));
    end
  end

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= RST_HOLD;
      rst_cnt <= '0;
      rst_q   <= 1'b0;
      bl_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (state == RST_HOLD && rst_cnt != RST_LAST) rst_cnt <= rst_cnt + RCW'(1);
      rst_q <= (state_next != RST_HOLD);
      bl_q  <= (state_next == RUN);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RST_HOLD:   if (rst_cnt == RST_LAST) state_next = WAIT_FRAME;
      WAIT_FRAME: if (frame_end) state_next = RUN;
      RUN:        state_next = RUN;
      default:    state_next = RST_HOLD;
    endcase
  end

  logic          run, hact, vact;
  logic [CW-1:0] h_start, h_stop, v_start, v_stop, req_start, req_stop;

  assign run       = (state == RUN);
  assign h_start   = cur.hs + cur.hb;
  assign h_stop    = h_start + cur.hd;
  assign v_start   = cur.vs + cur.vb;
  assign v_stop    = v_start + cur.vd;
  assign req_start = h_start - LEAD;
  assign req_stop  = h_stop - LEAD;
  assign hact      = (cnt_h >= h_start) && (cnt_h < h_stop);
  assign vact      = (cnt_v >= v_start) && (cnt_v < v_stop);

  assign lcd_de      = hact && vact && run;
  assign data_req    = vact && run && (cnt_h >= req_start) && (cnt_h < req_stop);
  assign pixel_xpos  = data_req ? cnt_h - req_start : '0;
  assign pixel_ypos  = data_req ? cnt_v - v_start : '0;
  assign lcd_data    = lcd_de ? pixel_data : '0;
  assign lcd_hs      = (mode_hv && hs_on) ? HS_ACT : ~HS_ACT;
  assign lcd_vs      = (mode_hv && vs_on) ? VS_ACT : ~VS_ACT;
  assign lcd_pclk    = lcd_clk;
  assign lcd_rst     = rst_q;
  assign lcd_bl      = bl_q;
  assign frame_start = run && (cnt_h == '0) && (cnt_v == '0);
  assign timing_chg  = chg_q;
  assign active_w    = cur.hd;
  assign active_h    = cur.vd;

endmodule
`default_nettype wire

// File: tb/tb_rgb_lcd_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rgb_lcd_timing_gen: directed bench, REQ_LEAD=1 and REQ_LEAD=3 copies  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_rgb_lcd_timing_gen;

  logic        lcd_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [15:0] lcd_id = 16'h1234;
  logic        mode_hv = 1'b1;
  logic [15:0] pd1 = '0, p3a = '0, p3b = '0, p3c = '0;

  logic        req1, hs1, vs1, de1, pclk1, rst1, bl1, fs1, chg1;
  logic [10:0] x1, y1, aw1, ah1;
  logic [15:0] ld1;
  logic        req3, hs3, vs3, de3, pclk3, rst3, bl3, fs3, chg3;
  logic [10:0] x3, y3, aw3, ah3;
  logic [15:0] ld3;

  int checks = 0;
  int errors = 0;

  always #5 lcd_clk = ~lcd_clk;

  rgb_lcd_timing_gen #(.CW(11), .DW(16), .REQ_LEAD(1), .RST_CYCLES(1000)) dut1 (
    .lcd_clk(lcd_clk), .sys_rst_n(sys_rst_n), .lcd_id(lcd_id), .mode_hv(mode_hv),
    .pixel_data(pd1), .data_req(req1), .pixel_xpos(x1), .pixel_ypos(y1),
    .lcd_hs(hs1), .lcd_vs(vs1), .lcd_de(de1), .lcd_data(ld1), .lcd_pclk(pclk1),
    .lcd_rst(rst1), .lcd_bl(bl1), .frame_start(fs1), .timing_chg(chg1),
    .active_w(aw1), .active_h(ah1));

  rgb_lcd_timing_gen #(.CW(11), .DW(16), .REQ_LEAD(3), .RST_CYCLES(1000)) dut3 (
    .lcd_clk(lcd_clk), .sys_rst_n(sys_rst_n), .lcd_id(lcd_id), .mode_hv(mode_hv),
    .pixel_data(p3c), .data_req(req3), .pixel_xpos(x3), .pixel_ypos(y3),
    .lcd_hs(hs3), .lcd_vs(vs3), .lcd_de(de3), .lcd_data(ld3), .lcd_pclk(pclk3),
    .lcd_rst(rst3), .lcd_bl(bl3), .frame_start(fs3), .timing_chg(chg3),
    .active_w(aw3), .active_h(ah3));

  // Pixel source: returns the requested column REQ_LEAD cycles later.
  always @(posedge lcd_clk) begin
    pd1 <= {5'd0, x1};
    p3a <= {5'd0, x3};
    p3b <= p3a;
    p3c <= p3b;
  end

  task automatic test_reset();
    repeat (5) @(negedge lcd_clk);
    checks++; if (rst1 !== 1'b0) begin errors++; $display("FAIL reset_lcd_rst: got %b want 0", rst1); end
    checks++; if (bl1 !== 1'b0) begin errors++; $display("FAIL reset_lcd_bl: got %b want 0", bl1); end
    checks++; if ({de1, req1, fs1, chg1} !== 4'b0000)
      begin errors++; $display("FAIL reset_flags: de/req/fs/chg got %b want 0000", {de1, req1, fs1, chg1}); end
    checks++; if ({x1, y1} !== 22'd0) begin errors++; $display("FAIL reset_pos: got %0d,%0d want 0,0", x1, y1); end
    checks++; if (ld1 !== 16'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", ld1); end
    checks++; if ({hs1, vs1} !== 2'b11) begin errors++; $display("FAIL reset_sync: hs/vs got %b want 11", {hs1, vs1}); end
    checks++; if (aw1 !== 11'd480 || ah1 !== 11'd272)
      begin errors++; $display("FAIL reset_active: got %0dx%0d want 480x272", aw1, ah1); end
  endtask

  task automatic test_powerup();
    int n = 0;
    int viol = 0;
    mode_hv = 1'b0;
    sys_rst_n = 1'b1;
    while (rst1 === 1'b0 && n < 5000) begin
      @(negedge lcd_clk); n++;
      if (bl1 !== 1'b0 || de1 !== 1'b0 || req1 !== 1'b0) viol++;
    end
    checks++; if (n != 1000) begin errors++; $display("FAIL powerup_rst_len: got %0d want 1000", n); end
    while (fs1 !== 1'b1 && n < 160000) begin
      @(negedge lcd_clk); n++;
      if (fs1 !== 1'b1 && (bl1 !== 1'b0 || de1 !== 1'b0 || req1 !== 1'b0)) viol++;
    end
    checks++; if (n != 150150) begin errors++; $display("FAIL powerup_first_frame: got %0d want 150150", n); end
    checks++; if (viol != 0) begin errors++; $display("FAIL powerup_quiet: got %0d active cycles want 0", viol); end
    checks++; if (bl1 !== 1'b1 || rst1 !== 1'b1)
      begin errors++; $display("FAIL powerup_run: bl/rst got %b%b want 11", bl1, rst1); end
    checks++; if (chg1 !== 1'b0) begin errors++; $display("FAIL unknown_id_chg: got %b want 0", chg1); end
    checks++; if (aw1 !== 11'd480 || ah1 !== 11'd272)
      begin errors++; $display("FAIL unknown_id_active: got %0dx%0d want 480x272", aw1, ah1); end
  endtask

  task automatic test_de_frame();
    int de_cnt = 0, fs_cnt = 0, first_de = -1, derr1 = 0, derr3 = 0, sync_viol = 0, hs_low = 0;
    logic [15:0] ex1 = '0, ex3 = '0;
    for (int i = 0; i < 150150; i++) begin
      if (fs1 === 1'b1) fs_cnt++;
      if (de1 === 1'b1) begin
        de_cnt++;
        if (first_de < 0) first_de = i;
        if (ld1 !== ex1) derr1++;
        ex1++;
      end else begin
        if (ld1 !== 16'd0) derr1++;
        ex1 = '0;
      end
      if (de3 === 1'b1) begin
        if (ld3 !== ex3) derr3++;
        ex3++;
      end else ex3 = '0;
      if (i < 149100) begin
        if (hs1 !== 1'b1 || vs1 !== 1'b1) sync_viol++;
      end else if (hs1 === 1'b0) hs_low++;
      if (i == 6342) begin
        checks++; if (req1 !== 1'b1 || x1 !== 11'd0 || y1 !== 11'd0 || de1 !== 1'b0)
          begin errors++; $display("FAIL lead1_start: req/x/y/de got %b/%0d/%0d/%b want 1/0/0/0", req1, x1, y1, de1); end
      end
      if (i == 6340) begin
        checks++; if (req3 !== 1'b1 || x3 !== 11'd0 || de3 !== 1'b0)
          begin errors++; $display("FAIL lead3_start: req/x/de got %b/%0d/%b want 1/0/0", req3, x3, de3); end
      end
      if (i == 6339) begin
        checks++; if (req3 !== 1'b0) begin errors++; $display("FAIL lead3_pre: req got %b want 0", req3); end
      end
      if (i == 6819) begin
        checks++; if (req3 !== 1'b1 || x3 !== 11'd479)
          begin errors++; $display("FAIL lead3_last: req/x got %b/%0d want 1/479", req3, x3); end
      end
      if (i == 6820) begin
        checks++; if (req3 !== 1'b0 || de3 !== 1'b1)
          begin errors++; $display("FAIL lead3_end: req/de got %b/%b want 0/1", req3, de3); end
      end
      if (i == 6823) begin
        checks++; if (de3 !== 1'b0) begin errors++; $display("FAIL lead3_de_fall: de got %b want 0", de3); end
      end
      if (i == 283 * 525 + 42) begin
        checks++; if (y1 !== 11'd271) begin errors++; $display("FAIL last_row_ypos: got %0d want 271", y1); end
      end
      if (i == 284 * 525 + 42) begin
        checks++; if (req1 !== 1'b0) begin errors++; $display("FAIL after_active_req: got %b want 0", req1); end
      end
      if (i == 150149) begin
        checks++; if (aw1 !== 11'd480 || chg1 !== 1'b0)
          begin errors++; $display("FAIL midframe_id_hold: w/chg got %0d/%b want 480/0", aw1, chg1); end
      end
      if (i == 75000) lcd_id = 16'h7016;
      if (i == 149099) mode_hv = 1'b1;
      @(negedge lcd_clk);
    end
    checks++; if (de_cnt != 130560) begin errors++; $display("FAIL de_count: got %0d want 130560", de_cnt); end
    checks++; if (first_de != 6343) begin errors++; $display("FAIL first_de: got %0d want 6343", first_de); end
    checks++; if (fs_cnt != 1) begin errors++; $display("FAIL frame_start_count: got %0d want 1", fs_cnt); end
    checks++; if (derr1 != 0) begin errors++; $display("FAIL lead1_data: got %0d bad pixels want 0", derr1); end
    checks++; if (derr3 != 0) begin errors++; $display("FAIL lead3_data: got %0d bad pixels want 0", derr3); end
    checks++; if (sync_viol != 0) begin errors++; $display("FAIL de_mode_sync: got %0d active cycles want 0", sync_viol); end
    checks++; if (hs_low != 82) begin errors++; $display("FAIL hv_hs_4342: got %0d low cycles want 82", hs_low); end
    checks++; if (fs1 !== 1'b1) begin errors++; $display("FAIL frame_len_4342: frame_start got %b want 1", fs1); end
  endtask

  task automatic test_timing_change();
    int hs_low = 0, vs_low = 0, de_cnt = 0, first_de = -1;
    checks++; if (chg1 !== 1'b1) begin errors++; $display("FAIL timing_chg_pulse: got %b want 1", chg1); end
    checks++; if (aw1 !== 11'd1024 || ah1 !== 11'd600)
      begin errors++; $display("FAIL new_active: got %0dx%0d want 1024x600", aw1, ah1); end
    for (int j = 0; j < 32256; j++) begin
      if (hs1 === 1'b0) hs_low++;
      if (vs1 === 1'b0) vs_low++;
      if (de1 === 1'b1) begin de_cnt++; if (first_de < 0) first_de = j; end
      if (j == 1) begin
        checks++; if (chg1 !== 1'b0) begin errors++; $display("FAIL timing_chg_width: got %b want 0", chg1); end
      end
      if (j == 31071) begin
        checks++; if (req1 !== 1'b1 || x1 !== 11'd0)
          begin errors++; $display("FAIL new_req_start: req/x got %b/%0d want 1/0", req1, x1); end
      end
      @(negedge lcd_clk);
    end
    checks++; if (hs_low != 480) begin errors++; $display("FAIL hv_hs_7016: got %0d want 480", hs_low); end
    checks++; if (vs_low != 4032) begin errors++; $display("FAIL hv_vs_7016: got %0d want 4032", vs_low); end
    checks++; if (first_de != 31072) begin errors++; $display("FAIL first_de_7016: got %0d want 31072", first_de); end
    checks++; if (de_cnt != 1024) begin errors++; $display("FAIL de_line_7016: got %0d want 1024", de_cnt); end
  endtask

  task automatic test_reset_mid_run();
    #2 sys_rst_n = 1'b0;
    #1;
    checks++; if (bl1 !== 1'b0 || rst1 !== 1'b0)
      begin errors++; $display("FAIL midrun_reset_pins: bl/rst got %b%b want 00", bl1, rst1); end
    checks++; if (de1 !== 1'b0 || req1 !== 1'b0 || hs1 !== 1'b1 || vs1 !== 1'b1)
      begin errors++; $display("FAIL midrun_reset_outs: de/req/hs/vs got %b%b%b%b want 0011", de1, req1, hs1, vs1); end
    checks++; if (aw1 !== 11'd480 || ah1 !== 11'd272)
      begin errors++; $display("FAIL midrun_reset_timing: got %0dx%0d want 480x272", aw1, ah1); end
    @(negedge lcd_clk);
    sys_rst_n = 1'b1;
    repeat (10) @(negedge lcd_clk);
    checks++; if (bl1 !== 1'b0 || rst1 !== 1'b0)
      begin errors++; $display("FAIL midrun_restart: bl/rst got %b%b want 00", bl1, rst1); end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_de_frame();
    test_timing_change();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
